// File: rtl/univ_shift_reg_if.sv
// Command/data bundle for univ_shift_reg: start/busy/done handshake plus
// parallel and serial data paths.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             start;
    logic [2:0]       mode;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] D;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] Q;
    logic             sout_l;
    logic             sout_r;
    logic             busy;
    logic             done;

    modport master (
        output start, mode, count, D, sin_l, sin_r,
        input  Q, sout_l, sout_r, busy, done
    );

    modport slave (
        input  start, mode, count, D, sin_l, sin_r,
        output Q, sout_l, sout_r, busy, done
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load/clear plus multi-cycle shift and
// rotate bursts driven by a start/busy/done handshake.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; single-cycle commands complete here
//   RUN   | one shift of the latched mode per edge until remaining=0
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    univ_shift_reg_if.slave    bus
);
    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_LOAD  = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_SHR   = 3'b011;
    localparam logic [2:0] M_ROTL  = 3'b100;
    localparam logic [2:0] M_ROTR  = 3'b101;
    localparam logic [2:0] M_ASR   = 3'b110;
    localparam logic [2:0] M_CLEAR = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [2:0]       mode_q;
    logic [CNT_W-1:0] remaining;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] shifted;
    logic             busy_r;
    logic             done_r;

    // Serial inputs are taken live so a stream can be fed during a burst.
    always_comb begin
        shifted = q_r;
        case (mode_q)
            M_SHL:   shifted = {q_r[WIDTH-2:0], bus.sin_r};
            M_SHR:   shifted = {bus.sin_l, q_r[WIDTH-1:1]};
            M_ROTL:  shifted = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
            M_ROTR:  shifted = {q_r[0], q_r[WIDTH-1:1]};
            M_ASR:   shifted = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
            default: shifted = q_r;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            mode_q    <= M_HOLD;
            remaining <= '0;
            q_r       <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        mode_q <= bus.mode;
                        case (bus.mode)
                            M_HOLD:  done_r <= 1'b1;
                            M_LOAD: begin
                                q_r    <= bus.D;
                                done_r <= 1'b1;
                            end
                            M_CLEAR: begin
                                q_r    <= '0;
                                done_r <= 1'b1;
                            end
                            default: begin
                                if (bus.count == '0) begin
                                    done_r <= 1'b1;
                                end else begin
                                    state     <= RUN;
                                    busy_r    <= 1'b1;
                                    remaining <= bus.count;
                                end
                            end
                        endcase
                    end
                end
                RUN: begin
                    q_r       <= shifted;
                    remaining <= remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Q      = q_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.sout_l = q_r[WIDTH-1];
    assign bus.sout_r = q_r[0];
endmodule
